tpumac: RTL and testbench

- Single processing element of a weight-stationary-free, output-stationary systolic array (TPU-style matrix multiply).
- Each cycle it passes its A operand east and its B operand south through registers, and accumulates the signed product A*B into a local C accumulator.
- The C accumulator can be loaded directly, for preload or clear, and is readable at all times.
- Instantiated in an N x N grid by the array top. Aout/Bout of one cell drive Ain/Bin of its neighbours.

---
 rtl/tpu_pkg.sv | 10 +
 rtl/tpu_mult.sv | 11 +
 rtl/tpumac.sv | 61 ++++++
 tb/tb_tpumac.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared widths and operand/accumulator types for the systolic array,
// its processing elements and their benches.
package tpu_pkg;
    localparam int BITS_AB = 8;
    localparam int BITS_C  = 16;
    localparam int DIM     = 4;

    typedef logic signed [BITS_AB-1:0] ab_t;
    typedef logic signed [BITS_C-1:0]  c_t;
endpackage

// File: rtl/tpu_mult.sv
// Combinational full-precision signed multiplier; isolated so a pipelined
// or DSP-mapped implementation can replace it without touching the cell.
module tpu_mult #(
    parameter int W = 8
) (
    input  logic signed [W-1:0]   a_i,
    input  logic signed [W-1:0]   b_i,
    output logic signed [2*W-1:0] p_o
);
    assign p_o = a_i * b_i;
endmodule

// File: rtl/tpumac.sv
// Output-stationary systolic PE: forwards A east and B south through
// registers and accumulates Ain*Bin into a loadable C register.
module tpumac
    import tpu_pkg::*;
#(
    parameter int BITS_AB = tpu_pkg::BITS_AB,
    parameter int BITS_C  = tpu_pkg::BITS_C
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      WrEn,
    input  logic signed [BITS_AB-1:0] Ain,
    input  logic signed [BITS_AB-1:0] Bin,
    input  logic signed [BITS_C-1:0]  Cin,
    output logic signed [BITS_AB-1:0] Aout,
    output logic signed [BITS_AB-1:0] Bout,
    output logic signed [BITS_C-1:0]  Cout
);
    logic signed [BITS_AB-1:0]   a_q, b_q;
    logic signed [BITS_C-1:0]    c_q, c_d;
    logic signed [2*BITS_AB-1:0] prod;
    logic signed [BITS_C-1:0]    prod_ext;

    tpu_mult #(.W(BITS_AB)) u_mult (
        .a_i (Ain),
        .b_i (Bin),
        .p_o (prod)
    );

    // Signed size cast sign-extends the product to the accumulator width.
    assign prod_ext = BITS_C'(prod);

    // Load wins over accumulate; the sum wraps modulo 2^BITS_C.
    always_comb begin
        c_d = c_q;
        if (WrEn) begin
            c_d = Cin;
        end else if (en) begin
            c_d = c_q + prod_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else begin
            if (en) begin
                a_q <= Ain;
                b_q <= Bin;
            end
            c_q <= c_d;
        end
    end

    assign Aout = a_q;
    assign Bout = b_q;
    assign Cout = c_q;
endmodule

// File: tb/tb_tpumac.sv
// Randomised and directed bench for the tpumac processing element with an
// expected-response queue and a free-running monitor.
module tb_tpumac;
    import tpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic WrEn = 1'b0;
    ab_t  Ain = '0;
    ab_t  Bin = '0;
    c_t   Cin = '0;
    ab_t  Aout, Bout;
    c_t   Cout;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state held as plain integers.
    int a_m = 0;
    int b_m = 0;
    int c_m = 0;

    logic [31:0] exp_q[$];

    tpumac #(.BITS_AB(BITS_AB), .BITS_C(BITS_C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .WrEn  (WrEn),
        .Ain   (Ain),
        .Bin   (Bin),
        .Cin   (Cin),
        .Aout  (Aout),
        .Bout  (Bout),
        .Cout  (Cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int wrap16(input int v);
        int r;
        r = v & 32'h0000_FFFF;
        if (r >= 32768) r = r - 65536;
        return r;
    endfunction

    function automatic logic [31:0] pack_exp();
        logic [7:0]  a8;
        logic [7:0]  b8;
        logic [15:0] c16;
        a8  = 8'(a_m);
        b8  = 8'(b_m);
        c16 = 16'(c_m);
        return {a8, b8, c16};
    endfunction

    // Applies one cycle of stimulus and records the state expected after the edge.
    task automatic drive(input bit e, input bit w, input int a, input int b, input int cin);
        @(negedge clk);
        en   = e;
        WrEn = w;
        Ain  = ab_t'(a);
        Bin  = ab_t'(b);
        Cin  = c_t'(cin);
        if (w)      c_m = wrap16(cin);
        else if (e) c_m = wrap16(c_m + a * b);
        if (e) begin
            a_m = a;
            b_m = b;
        end
        exp_q.push_back(pack_exp());
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_aout"}, 32'(Aout), 32'd0);
        check({tag, "_bout"}, 32'(Bout), 32'd0);
        check({tag, "_cout"}, 32'(Cout), 32'd0);
    endtask

    // Monitor: every edge following a drive has one queued expectation.
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("aout", {24'd0, Aout}, {24'd0, e[31:24]});
                check("bout", {24'd0, Bout}, {24'd0, e[23:16]});
                check("cout", {16'd0, Cout}, {16'd0, e[15:0]});
            end
        end
    end

    initial begin
        int wait_cycles;

        @(posedge clk);
        #1;
        check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Pass-through and hold
        drive(1, 0, 5, -3, 0);
        drive(0, 0, 7, 0, 0);
        // Clear then accumulate: 12, 2, 16386
        drive(0, 1, 0, 0, 0);
        drive(1, 0, 3, 4, 0);
        drive(1, 0, -2, 5, 0);
        drive(1, 0, -128, -128, 0);
        // Load priority
        drive(0, 1, 0, 0, 100);
        drive(1, 1, 10, 10, -7);
        drive(0, 1, 0, 0, 42);
        // Wrap-around both directions
        drive(0, 1, 0, 0, 32767);
        drive(1, 0, 1, 1, 0);
        drive(1, 0, -1, 1, 0);

        // Asynchronous reset mid-cycle with a loaded accumulator
        drive(0, 1, 0, 0, 16'h0123);
        @(posedge clk);
        #2;
        en   = 1'b0;
        WrEn = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        #1;
        check_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        a_m = 0;
        b_m = 0;
        c_m = 0;
        drive(1, 0, 6, 7, 0);

        for (int i = 0; i < 1000; i++) begin
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                  $urandom_range(0, 65535) - 32768);
        end

        @(negedge clk);
        en   = 1'b0;
        WrEn = 1'b0;
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 5) begin
            @(negedge clk);
            wait_cycles++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
